// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter that funnels several Avalon-style masters onto one DDR command port.
// A small tag FIFO of port ids steers in-order read responses back to their requesters.
module ddr_port_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_WIDTH  = 30,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_PENDING = 4
) (
    input  logic                                  clk_clk,
    input  logic                                  reset_reset_n,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       port_address,
    input  logic [NUM_PORTS-1:0]                  port_read,
    input  logic [NUM_PORTS-1:0]                  port_write,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]       port_writedata,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   port_byteenable,
    output logic [NUM_PORTS-1:0]                  port_waitrequest,
    output logic [DATA_WIDTH-1:0]                 port_readdata,
    output logic [NUM_PORTS-1:0]                  port_readdatavalid,
    output logic [ADDR_WIDTH-1:0]                 mem_address,
    output logic                                  mem_read,
    output logic                                  mem_write,
    output logic [DATA_WIDTH-1:0]                 mem_writedata,
    output logic [DATA_WIDTH/8-1:0]               mem_byteenable,
    input  logic                                  mem_waitrequest,
    input  logic [DATA_WIDTH-1:0]                 mem_readdata,
    input  logic                                  mem_readdatavalid,
    output logic                                  err_unexpected
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int ID_WIDTH  = $clog2(NUM_PORTS);
    localparam int PTR_WIDTH = $clog2(MAX_PENDING);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ID_WIDTH-1:0]    r_grant;
    logic [ID_WIDTH-1:0]    w_grant_next;
    logic [ID_WIDTH-1:0]    r_rr_last;
    logic [ID_WIDTH-1:0]    w_rr_last_next;

    logic [ID_WIDTH-1:0]    r_tag_mem [MAX_PENDING];
    logic [PTR_WIDTH-1:0]   r_wr_ptr;
    logic [PTR_WIDTH-1:0]   r_rd_ptr;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   r_err;

    logic [ADDR_WIDTH-1:0]  w_addr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  w_wdata [NUM_PORTS];
    logic [BE_WIDTH-1:0]    w_be    [NUM_PORTS];
    logic [NUM_PORTS-1:0]   w_req;

    logic                   w_busy;
    logic                   w_g_read;
    logic                   w_g_write;
    logic                   w_g_rd_only;
    logic                   w_full;
    logic                   w_read_stall;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_found;
    logic [ID_WIDTH-1:0]    w_pick;

    function automatic logic [ID_WIDTH-1:0] wrap_id(input int v);
        return ID_WIDTH'(v % NUM_PORTS);
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign w_addr[gi]  = port_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata[gi] = port_writedata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_be[gi]    = port_byteenable[gi*BE_WIDTH +: BE_WIDTH];
            assign w_req[gi]   = port_read[gi] | port_write[gi];

            // Only the granted port can ever see waitrequest low.
            assign port_waitrequest[gi] = !(w_busy && (r_grant == ID_WIDTH'(gi)))
                                          || mem_waitrequest || w_read_stall;

            assign port_readdatavalid[gi] = w_pop && (r_tag_mem[r_rd_ptr] == ID_WIDTH'(gi));
        end
    endgenerate

    assign w_busy       = (r_state == ST_BUSY);
    assign w_g_read     = port_read[r_grant];
    assign w_g_write    = port_write[r_grant];
    assign w_g_rd_only  = w_g_read & ~w_g_write;
    assign w_full       = (r_count == CNT_WIDTH'(MAX_PENDING));
    assign w_read_stall = w_g_rd_only & w_full;

    assign mem_read       = w_busy & w_g_rd_only & ~w_full;
    assign mem_write      = w_busy & w_g_write;
    assign mem_address    = w_addr[r_grant];
    assign mem_writedata  = w_wdata[r_grant];
    assign mem_byteenable = w_be[r_grant];

    assign w_accept = (mem_read | mem_write) & ~mem_waitrequest;
    assign w_push   = w_accept & mem_read;
    assign w_pop    = mem_readdatavalid & (r_count != '0);

    assign port_readdata  = mem_readdata;
    assign err_unexpected = r_err;

    // Round-robin search starting just after the last served port.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!w_found && w_req[wrap_id(int'(r_rr_last) + k)]) begin
                w_found = 1'b1;
                w_pick  = wrap_id(int'(r_rr_last) + k);
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_rr_last_next = r_rr_last;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_next = w_pick;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_accept) begin
                    w_rr_last_next = r_grant;
                    w_state_next   = ST_IDLE;
                end else if (!(w_g_read || w_g_write)) begin
                    // Abandoned request: give up the slot but keep the fairness pointer.
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_rr_last <= ID_WIDTH'(NUM_PORTS - 1);
        end else begin
            r_state   <= w_state_next;
            r_grant   <= w_grant_next;
            r_rr_last <= w_rr_last_next;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (mem_readdatavalid && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: occupancy decides which entries are meaningful.
    always_ff @(posedge clk_clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= r_grant;
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Self-checking bench for ddr_port_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_ddr_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int MP = 4;
    localparam int BW = DW / 8;

    logic                 clk;
    logic                 rst_n;
    logic [NP*AW-1:0]     port_address;
    logic [NP-1:0]        port_read;
    logic [NP-1:0]        port_write;
    logic [NP*DW-1:0]     port_writedata;
    logic [NP*BW-1:0]     port_byteenable;
    logic [NP-1:0]        port_waitrequest;
    logic [DW-1:0]        port_readdata;
    logic [NP-1:0]        port_readdatavalid;
    logic [AW-1:0]        mem_address;
    logic                 mem_read;
    logic                 mem_write;
    logic [DW-1:0]        mem_writedata;
    logic [BW-1:0]        mem_byteenable;
    logic                 mem_waitrequest;
    logic [DW-1:0]        mem_readdata;
    logic                 mem_readdatavalid;
    logic                 err_unexpected;

    int n_checks = 0;
    int n_fail   = 0;

    ddr_port_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_PENDING(MP)
    ) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .port_address      (port_address),
        .port_read         (port_read),
        .port_write        (port_write),
        .port_writedata    (port_writedata),
        .port_byteenable   (port_byteenable),
        .port_waitrequest  (port_waitrequest),
        .port_readdata     (port_readdata),
        .port_readdatavalid(port_readdatavalid),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_byteenable    (mem_byteenable),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .err_unexpected    (err_unexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic        mw;
        logic        rv;
        logic [31:0] rdata;
        logic        e_mrd;
        logic        e_mwr;
        logic [29:0] e_addr;
        logic [3:0]  e_wait;
        logic [3:0]  e_rdv;
        logic        e_err;
    } vec_t;

    vec_t vt[$];

    // reference model state
    bit  m_busy;
    int  m_grant;
    int  m_rr;
    int  m_q[$];
    bit  m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [3:0] rd, input logic [3:0] wr, input logic mw,
                           input logic rv, input logic [31:0] rdata, input logic e_mrd,
                           input logic e_mwr, input logic [29:0] e_addr,
                           input logic [3:0] e_wait, input logic [3:0] e_rdv,
                           input logic e_err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.mw = mw; v.rv = rv; v.rdata = rdata;
        v.e_mrd = e_mrd; v.e_mwr = e_mwr; v.e_addr = e_addr;
        v.e_wait = e_wait; v.e_rdv = e_rdv; v.e_err = e_err;
        vt.push_back(v);
    endtask

    task automatic set_fixed_data();
        for (int i = 0; i < NP; i++) begin
            port_address[i*AW +: AW]    = AW'(32'h100 * i);
            port_writedata[i*DW +: DW]  = 32'hA000_0000 | 32'(i);
            port_byteenable[i*BW +: BW] = BW'(i + 1);
        end
    endtask

    task automatic idle_inputs();
        port_read         = '0;
        port_write        = '0;
        mem_waitrequest   = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset mem_read", mem_read, 0);
        check("reset mem_write", mem_write, 0);
        check("reset waitrequest", port_waitrequest, 4'hF);
        check("reset readdatavalid", port_readdatavalid, 0);
        check("reset err", err_unexpected, 0);
        rst_n = 1'b1;
        m_busy = 0; m_grant = 0; m_rr = NP - 1; m_q.delete(); m_err = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_table();
        for (int r = 0; r < vt.size(); r++) begin
            port_read         = vt[r].rd;
            port_write        = vt[r].wr;
            mem_waitrequest   = vt[r].mw;
            mem_readdatavalid = vt[r].rv;
            mem_readdata      = vt[r].rdata;
            @(negedge clk);
            check($sformatf("vec%0d mem_read", r), mem_read, vt[r].e_mrd);
            check($sformatf("vec%0d mem_write", r), mem_write, vt[r].e_mwr);
            if (vt[r].e_mrd || vt[r].e_mwr)
                check($sformatf("vec%0d mem_address", r), mem_address, vt[r].e_addr);
            check($sformatf("vec%0d waitrequest", r), port_waitrequest, vt[r].e_wait);
            check($sformatf("vec%0d readdatavalid", r), port_readdatavalid, vt[r].e_rdv);
            if (vt[r].e_rdv != 0)
                check($sformatf("vec%0d readdata", r), port_readdata, vt[r].rdata);
            check($sformatf("vec%0d err", r), err_unexpected, vt[r].e_err);
            next_cycle();
        end
        idle_inputs();
    endtask

    // One cycle of the reference model: compare outputs, then advance model state.
    task automatic model_cycle(input int cyc);
        bit          g_rd, g_wr, g_rd_only, full, e_mrd, e_mwr, accept, found;
        logic [3:0]  e_wait, e_rdv;
        g_rd      = port_read[m_grant];
        g_wr      = port_write[m_grant];
        g_rd_only = g_rd && !g_wr;
        full      = (m_q.size() == MP);
        e_mrd     = m_busy && g_rd_only && !full;
        e_mwr     = m_busy && g_wr;
        e_wait    = 4'hF;
        if (m_busy) e_wait[m_grant] = mem_waitrequest || (g_rd_only && full);
        e_rdv     = (mem_readdatavalid && m_q.size() > 0) ? 4'(1 << m_q[0]) : 4'h0;

        check($sformatf("rnd%0d mem_read", cyc), mem_read, e_mrd);
        check($sformatf("rnd%0d mem_write", cyc), mem_write, e_mwr);
        if (e_mrd || e_mwr)
            check($sformatf("rnd%0d mem_address", cyc), mem_address,
                  port_address[m_grant*AW +: AW]);
        if (e_mwr) begin
            check($sformatf("rnd%0d mem_writedata", cyc), mem_writedata,
                  port_writedata[m_grant*DW +: DW]);
            check($sformatf("rnd%0d mem_byteenable", cyc), mem_byteenable,
                  port_byteenable[m_grant*BW +: BW]);
        end
        check($sformatf("rnd%0d waitrequest", cyc), port_waitrequest, e_wait);
        check($sformatf("rnd%0d readdatavalid", cyc), port_readdatavalid, e_rdv);
        if (e_rdv != 0)
            check($sformatf("rnd%0d readdata", cyc), port_readdata, mem_readdata);
        check($sformatf("rnd%0d err", cyc), err_unexpected, m_err);

        accept = (e_mrd || e_mwr) && !mem_waitrequest;
        if (mem_readdatavalid) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_err = 1;
        end
        if (accept && e_mrd) m_q.push_back(m_grant);
        if (!m_busy) begin
            found = 0;
            for (int k = 1; k <= NP; k++) begin
                int idx;
                idx = (m_rr + k) % NP;
                if (!found && (port_read[idx] || port_write[idx])) begin
                    found   = 1;
                    m_grant = idx;
                    m_busy  = 1;
                end
            end
        end else if (accept) begin
            m_busy = 0;
            m_rr   = m_grant;
        end else if (!(g_rd || g_wr)) begin
            m_busy = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        set_fixed_data();

        // Directed vectors: single read, response ordering, write priority with
        // mem stall, abandoned grant leaving the round-robin pointer untouched.
        add_vec(4'b0010, 0, 0, 0, 0,             0, 0, 0,      4'hF,    0,       0);
        add_vec(4'b0010, 0, 0, 0, 0,             1, 0, 30'h100, 4'b1101, 0,      0);
        add_vec(0,       0, 0, 0, 0,             0, 0, 0,      4'hF,    0,       0);
        add_vec(0,       0, 0, 0, 0,             0, 0, 0,      4'hF,    0,       0);
        add_vec(0,       0, 0, 1, 32'hDEADBEEF,  0, 0, 0,      4'hF,    4'b0010, 0);
        add_vec(0,       0, 0, 0, 0,             0, 0, 0,      4'hF,    0,       0);
        add_vec(4'b0011, 0, 0, 0, 0,             0, 0, 0,      4'hF,    0,       0);
        add_vec(4'b0011, 0, 0, 0, 0,             1, 0, 30'h000, 4'b1110, 0,      0);
        add_vec(4'b0010, 0, 0, 0, 0,             0, 0, 0,      4'hF,    0,       0);
        add_vec(4'b0010, 0, 0, 0, 0,             1, 0, 30'h100, 4'b1101, 0,      0);
        add_vec(0,       0, 0, 1, 32'h1111AAAA,  0, 0, 0,      4'hF,    4'b0001, 0);
        add_vec(0,       0, 0, 1, 32'h2222BBBB,  0, 0, 0,      4'hF,    4'b0010, 0);
        add_vec(0,       0, 0, 0, 0,             0, 0, 0,      4'hF,    0,       0);
        add_vec(4'b0100, 4'b0100, 0, 0, 0,       0, 0, 0,      4'hF,    0,       0);
        add_vec(4'b0100, 4'b0100, 1, 0, 0,       0, 1, 30'h200, 4'hF,    0,       0);
        add_vec(4'b0100, 4'b0100, 0, 0, 0,       0, 1, 30'h200, 4'b1011, 0,      0);
        add_vec(0,       0, 0, 0, 0,             0, 0, 0,      4'hF,    0,       0);
        add_vec(0,       4'b1000, 0, 0, 0,       0, 0, 0,      4'hF,    0,       0);
        add_vec(0,       0, 0, 0, 0,             0, 0, 0,      4'b0111, 0,       0);
        add_vec(0,       4'b1001, 0, 0, 0,       0, 0, 0,      4'hF,    0,       0);
        add_vec(0,       4'b1001, 0, 0, 0,       0, 1, 30'h300, 4'b0111, 0,      0);
        add_vec(0,       0, 0, 0, 0,             0, 0, 0,      4'hF,    0,       0);

        do_reset();
        run_table();

        // Fairness: all ports write continuously, one accept every two cycles.
        do_reset();
        port_write = 4'hF;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check($sformatf("fair%0d mem_write", c), mem_write, (c % 2) == 1);
            if ((c % 2) == 1)
                check($sformatf("fair%0d grant addr", c), mem_address,
                      AW'(32'h100 * (((c - 1) / 2) % NP)));
            next_cycle();
        end
        idle_inputs();

        // Backpressure: four reads fill the tag FIFO, the fifth waits for a pop.
        do_reset();
        port_read = 4'b0001;
        for (int c = 0; c < 13; c++) begin
            bit exp_mrd;
            mem_readdatavalid = (c == 11);
            mem_readdata      = 32'h5555_0000 + 32'(c);
            exp_mrd = (c < 9) ? ((c % 2) == 1) : (c == 12);
            @(negedge clk);
            check($sformatf("bp%0d mem_read", c), mem_read, exp_mrd);
            check($sformatf("bp%0d waitrequest0", c), port_waitrequest[0], !exp_mrd);
            check($sformatf("bp%0d readdatavalid", c), port_readdatavalid,
                  (c == 11) ? 4'b0001 : 4'b0000);
            next_cycle();
        end
        idle_inputs();

        // Unexpected response sets a sticky error and is not forwarded.
        do_reset();
        mem_readdatavalid = 1'b1;
        @(negedge clk);
        check("err pulse readdatavalid", port_readdatavalid, 0);
        check("err before edge", err_unexpected, 0);
        next_cycle();
        mem_readdatavalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("err sticky%0d", c), err_unexpected, 1);
            next_cycle();
        end

        // Reset in the middle of operation with two reads outstanding.
        do_reset();
        port_read = 4'b0011;
        repeat (4) next_cycle();
        port_read = 4'b0001;
        next_cycle();
        @(negedge clk);
        check("midrst busy mem_read", mem_read, 1);
        next_cycle();
        rst_n = 1'b0;
        mem_readdatavalid = 1'b1;
        #1;
        check("midrst mem_read", mem_read, 0);
        check("midrst waitrequest", port_waitrequest, 4'hF);
        check("midrst readdatavalid", port_readdatavalid, 0);
        check("midrst err", err_unexpected, 0);
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;
        next_cycle();
        mem_readdatavalid = 1'b1;
        @(negedge clk);
        check("postrst readdatavalid", port_readdatavalid, 0);
        next_cycle();
        mem_readdatavalid = 1'b0;
        @(negedge clk);
        check("postrst err", err_unexpected, 1);
        next_cycle();

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            port_read         = 4'($urandom);
            port_write        = 4'($urandom & $urandom);
            mem_waitrequest   = ($urandom_range(0, 3) == 0);
            mem_readdatavalid = ($urandom_range(0, 2) == 0);
            mem_readdata      = $urandom;
            for (int i = 0; i < NP; i++) begin
                port_address[i*AW +: AW]    = AW'($urandom);
                port_writedata[i*DW +: DW]  = $urandom;
                port_byteenable[i*BW +: BW] = BW'($urandom);
            end
            @(negedge clk);
            model_cycle(c);
            next_cycle();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
